// File: rtl/shift_add_mult_if.sv
// Handshake and operand/result bundle for the shift-add multiplier.
// The requester drives start, mode bits and operands; the multiplier returns status and product.
interface shift_add_mult_if #(
   parameter int WIDTH = 4
);
   logic                   start;
   logic                   signed_mode;
   logic                   acc_en;
   logic [WIDTH-1:0]       op_a;
   logic [WIDTH-1:0]       op_b;
   logic                   busy;
   logic                   done;
   logic [2*WIDTH-1:0]     product;

   modport master (
      output start,
      output signed_mode,
      output acc_en,
      output op_a,
      output op_b,
      input  busy,
      input  done,
      input  product
   );

   modport slave (
      input  start,
      input  signed_mode,
      input  acc_en,
      input  op_a,
      input  op_b,
      output busy,
      output done,
      output product
   );
endinterface

// File: rtl/shift_add_mult.sv
// Sequential shift-add multiplier: WIDTH add/shift steps on operand magnitudes,
// sign fix-up and optional accumulation into the product register on completion.
module shift_add_mult #(
   parameter int WIDTH = 4
) (
   input  logic            sys_clk,
   input  logic            sys_rst,
   shift_add_mult_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       count_q, count_d;
   logic [2*WIDTH:0]    partial_q, partial_d;
   logic [WIDTH-1:0]    mcand_q, mcand_d;
   logic                neg_q, neg_d;
   logic                acc_q, acc_d;
   logic [2*WIDTH-1:0]  product_q, product_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic [WIDTH-1:0]    mag_a;
   logic [WIDTH-1:0]    mag_b;
   logic [WIDTH:0]      upper_sum;
   logic [2*WIDTH:0]    stepped;
   logic [2*WIDTH-1:0]  result;

   // The partial register holds the running sum in its upper WIDTH+1 bits and the
   // not-yet-consumed multiplier bits in its lower WIDTH bits.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      partial_d = partial_q;
      mcand_d   = mcand_q;
      neg_d     = neg_q;
      acc_d     = acc_q;
      product_d = product_q;
      busy_d    = 1'b0;
      done_d    = 1'b0;

      mag_a     = (bus.signed_mode && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
      mag_b     = (bus.signed_mode && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;
      upper_sum = partial_q[2*WIDTH:WIDTH] + {1'b0, mcand_q};
      stepped   = partial_q[0] ? {upper_sum, partial_q[WIDTH-1:0]} : partial_q;
      result    = neg_q ? -partial_q[2*WIDTH-1:0] : partial_q[2*WIDTH-1:0];

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d   = CALC;
               busy_d    = 1'b1;
               count_d   = '0;
               mcand_d   = mag_a;
               partial_d = {{(WIDTH+1){1'b0}}, mag_b};
               neg_d     = bus.signed_mode & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
               acc_d     = bus.acc_en;
            end
         end
         CALC: begin
            busy_d    = 1'b1;
            partial_d = stepped >> 1;
            if (count_q == LAST) begin
               state_d = FIN;
            end else begin
               count_d = count_q + CW'(1);
            end
         end
         // busy stays high through the done cycle, so a start is only taken
         // once the FSM is back in IDLE.
         FIN: begin
            busy_d    = 1'b1;
            done_d    = 1'b1;
            product_d = acc_q ? (product_q + result) : result;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q   <= IDLE;
         count_q   <= '0;
         partial_q <= '0;
         mcand_q   <= '0;
         neg_q     <= 1'b0;
         acc_q     <= 1'b0;
         product_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         partial_q <= partial_d;
         mcand_q   <= mcand_d;
         neg_q     <= neg_d;
         acc_q     <= acc_d;
         product_q <= product_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.product = product_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed bench for shift_add_mult: WIDTH=4, 8 and 16 instances share one clock and reset;
// each scenario task compares outputs against hand-computed products and timing.
module tb_shift_add_mult;
   logic sys_clk;
   logic sys_rst;
   int   total;
   int   bad;

   shift_add_mult_if #(.WIDTH(4))  if4 ();
   shift_add_mult_if #(.WIDTH(8))  if8 ();
   shift_add_mult_if #(.WIDTH(16)) if16 ();

   shift_add_mult #(.WIDTH(4)) dut4 (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .bus     (if4.slave)
   );

   shift_add_mult #(.WIDTH(8)) dut8 (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .bus     (if8.slave)
   );

   shift_add_mult #(.WIDTH(16)) dut16 (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .bus     (if16.slave)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic drive(input int w, input logic st, input logic [15:0] a, input logic [15:0] b,
                        input logic sgn, input logic acc);
      case (w)
         4: begin
            if4.start = st; if4.op_a = a[3:0]; if4.op_b = b[3:0];
            if4.signed_mode = sgn; if4.acc_en = acc;
         end
         8: begin
            if8.start = st; if8.op_a = a[7:0]; if8.op_b = b[7:0];
            if8.signed_mode = sgn; if8.acc_en = acc;
         end
         default: begin
            if16.start = st; if16.op_a = a; if16.op_b = b;
            if16.signed_mode = sgn; if16.acc_en = acc;
         end
      endcase
   endtask

   function automatic logic get_busy(input int w);
      get_busy = if16.busy;
      if (w == 4) get_busy = if4.busy;
      else if (w == 8) get_busy = if8.busy;
   endfunction

   function automatic logic get_done(input int w);
      get_done = if16.done;
      if (w == 4) get_done = if4.done;
      else if (w == 8) get_done = if8.done;
   endfunction

   function automatic logic [31:0] get_prod(input int w);
      get_prod = if16.product;
      if (w == 4) get_prod = {24'd0, if4.product};
      else if (w == 8) get_prod = {16'd0, if8.product};
   endfunction

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   // One start pulse; checks latency, busy span, product and that done lasts one cycle.
   task automatic do_mult(input int w, input logic [15:0] a, input logic [15:0] b, input logic sgn,
                          input logic acc, input logic [31:0] exp_p, input string name);
      int lat;
      int busy_cycles;
      bit seen;
      drive(w, 1'b1, a, b, sgn, acc);
      tick();
      drive(w, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      busy_cycles = get_busy(w) ? 1 : 0;
      seen = 1'b0;
      lat = 0;
      for (int k = 1; k <= 40 && !seen; k++) begin
         tick();
         if (get_done(w)) begin
            seen = 1'b1;
            lat = k;
         end
         if (get_busy(w)) busy_cycles++;
      end
      total++;
      if (!seen) begin
         bad++;
         $display("[TB] FAIL %s timeout: no done within 40 cycles", name);
      end else begin
         if (lat !== w + 1) begin
            bad++;
            $display("[TB] FAIL %s latency: got %0d want %0d", name, lat, w + 1);
         end
         total++;
         if (get_prod(w) !== exp_p) begin
            bad++;
            $display("[TB] FAIL %s product: got %h want %h", name, get_prod(w), exp_p);
         end
         total++;
         if (busy_cycles !== w + 2) begin
            bad++;
            $display("[TB] FAIL %s busy_cycles: got %0d want %0d", name, busy_cycles, w + 2);
         end
      end
      tick();
      total++;
      if (get_done(w) !== 1'b0 || get_busy(w) !== 1'b0) begin
         bad++;
         $display("[TB] FAIL %s idle_after: done=%b busy=%b want 0 0", name, get_done(w), get_busy(w));
      end
   endtask

   // Reset held with start asserted: everything must come up idle and cleared.
   task automatic test_reset();
      sys_rst = 1'b1;
      drive(4, 1'b1, 16'hF, 16'hF, 1'b0, 1'b0);
      tick();
      tick();
      for (int w = 4; w <= 16; w = w * 2) begin
         total++;
         if (get_busy(w) !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_busy w=%0d: got %b want 0", w, get_busy(w));
         end
         total++;
         if (get_done(w) !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_done w=%0d: got %b want 0", w, get_done(w));
         end
         total++;
         if (get_prod(w) !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_product w=%0d: got %h want 0", w, get_prod(w));
         end
      end
      drive(4, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      sys_rst = 1'b0;
      tick();
   endtask

   task automatic test_unsigned();
      do_mult(4, 16'hF, 16'hF, 1'b0, 1'b0, 32'hE1, "u_15x15");
      do_mult(4, 16'h0, 16'h0, 1'b0, 1'b0, 32'h00, "u_0x0");
      do_mult(4, 16'hA, 16'h6, 1'b0, 1'b0, 32'h3C, "u_10x6");
   endtask

   task automatic test_signed();
      do_mult(4, 16'h8, 16'h8, 1'b1, 1'b0, 32'h40, "s_m8xm8");
      do_mult(4, 16'h8, 16'h7, 1'b1, 1'b0, 32'hC8, "s_m8x7");
      do_mult(4, 16'h5, 16'hD, 1'b1, 1'b0, 32'hF1, "s_5xm3");
      do_mult(4, 16'h0, 16'h8, 1'b1, 1'b0, 32'h00, "s_0xm8");
   endtask

   task automatic test_accumulate();
      do_mult(4, 16'h3, 16'h5, 1'b0, 1'b0, 32'h0F, "acc_seed");
      do_mult(4, 16'h2, 16'h4, 1'b0, 1'b1, 32'h17, "acc_add");
      do_mult(4, 16'hF, 16'h1, 1'b1, 1'b1, 32'h16, "acc_signed");
      do_mult(4, 16'hF, 16'hF, 1'b0, 1'b0, 32'hE1, "acc_wrap_seed");
      do_mult(4, 16'hF, 16'hF, 1'b0, 1'b1, 32'hC2, "acc_wrap");
   endtask

   // start held high: operands changed while busy must be ignored, the next
   // accepted start uses what is present on the edge after the done cycle.
   task automatic test_back_to_back();
      int dones;
      int t1;
      int t2;
      logic [31:0] p1;
      logic [31:0] p2;
      dones = 0; t1 = 0; t2 = 0; p1 = '0; p2 = '0;
      drive(4, 1'b1, 16'h3, 16'h4, 1'b0, 1'b0);
      tick();
      drive(4, 1'b1, 16'h9, 16'h9, 1'b0, 1'b0);
      for (int k = 1; k <= 16; k++) begin
         tick();
         if (get_done(4)) begin
            dones++;
            if (dones == 1) begin t1 = k; p1 = get_prod(4); end
            else begin t2 = k; p2 = get_prod(4); end
         end
         if (k == 5) drive(4, 1'b1, 16'h6, 16'h7, 1'b0, 1'b0);
         if (k == 6) begin
            total++;
            if (get_busy(4) !== 1'b1) begin
               bad++;
               $display("[TB] FAIL b2b_reaccept_busy: got %b want 1", get_busy(4));
            end
            drive(4, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
         end
      end
      total++;
      if (dones !== 2) begin
         bad++;
         $display("[TB] FAIL b2b_done_count: got %0d want 2", dones);
      end
      total++;
      if (t1 !== 5 || p1 !== 32'h0C) begin
         bad++;
         $display("[TB] FAIL b2b_first: t=%0d p=%h want t=5 p=0c", t1, p1);
      end
      total++;
      if (t2 !== 11 || p2 !== 32'h2A) begin
         bad++;
         $display("[TB] FAIL b2b_second: t=%0d p=%h want t=11 p=2a", t2, p2);
      end
   endtask

   task automatic test_reset_abort();
      int dones;
      dones = 0;
      drive(4, 1'b1, 16'h7, 16'h7, 1'b0, 1'b0);
      tick();
      drive(4, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      tick();
      sys_rst = 1'b1;
      tick();
      sys_rst = 1'b0;
      total++;
      if (get_busy(4) !== 1'b0 || get_done(4) !== 1'b0 || get_prod(4) !== 32'h0) begin
         bad++;
         $display("[TB] FAIL abort_state: busy=%b done=%b product=%h want 0 0 0",
                  get_busy(4), get_done(4), get_prod(4));
      end
      for (int k = 0; k < 10; k++) begin
         tick();
         if (get_done(4)) dones++;
      end
      total++;
      if (dones !== 0) begin
         bad++;
         $display("[TB] FAIL abort_no_done: got %0d dones want 0", dones);
      end
      do_mult(4, 16'h3, 16'h3, 1'b0, 1'b0, 32'h09, "after_abort");
   endtask

   task automatic test_wide();
      do_mult(8, 16'hFF, 16'hFF, 1'b0, 1'b0, 32'hFE01, "w8_255x255");
      do_mult(8, 16'h80, 16'h80, 1'b1, 1'b0, 32'h4000, "w8_m128xm128");
      do_mult(8, 16'h80, 16'h7F, 1'b1, 1'b0, 32'hC080, "w8_m128x127");
      do_mult(16, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 32'hFFFE0001, "w16_max");
      do_mult(16, 16'h8000, 16'hFFFF, 1'b1, 1'b0, 32'h00008000, "w16_min_x_m1");
   endtask

   initial begin
      total = 0;
      bad = 0;
      sys_rst = 1'b1;
      drive(4, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      drive(8, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      drive(16, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      test_reset();
      test_unsigned();
      test_signed();
      test_accumulate();
      test_back_to_back();
      test_reset_abort();
      test_wide();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/shift_add_mult.md
# shift_add_mult

Parametrised sequential shift-add multiplier, the next generation of the fixed 4x4 control-unit/datapath multiplier. It multiplies two WIDTH-bit operands over WIDTH iteration cycles and produces a 2*WIDTH-bit product. It adds a start/busy/done handshake, signed (two's complement) mode, and an accumulate mode that adds the new product to the previous result. It sits between the pin-level input registers and the output bus of the top-level wrapper.

## Interface
- WIDTH, 4: operand width in bits; legal range 2..16; product width is 2*WIDTH.
- sys_clk  in  1  single clock; all state changes on the rising edge.
- sys_rst  in  1  reset, synchronous, active-high.
- start  in  1  request a multiply; sampled only in IDLE.
- signed_mode  in  1  1 = operands and product are two's complement; 0 = unsigned; latched with start.
- acc_en  in  1  1 = result is previous product + a*b; 0 = result is a*b; latched with start.
- op_a  in  WIDTH  multiplicand; latched with start.
- op_b  in  WIDTH  multiplier; latched with start.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse; product is newly valid.
- product  out  2*WIDTH  result register; holds its value until the next done or reset.

## Operation
- States:
  - IDLE: wait for start. start=1 latches the operands, mode bits and signs; goes to CALC with iteration count = 0.
  - CALC: one shift-add step per cycle for WIDTH cycles; goes to FIN after step WIDTH-1.
  - FIN: product register updated, done=1; returns to IDLE unconditionally.
- Transitions: IDLE->CALC on start; CALC->CALC while count < WIDTH-1; CALC->FIN when count = WIDTH-1; FIN->IDLE always.
- Datapath:
  - On load, magnitudes are formed. In unsigned mode the magnitudes are op_a and op_b as given. In signed mode each magnitude is the absolute value, held as a WIDTH-bit unsigned value, so -2^(WIDTH-1) is legal and gives magnitude 2^(WIDTH-1).
  - neg = signed_mode & (a_msb ^ b_msb).
  - Each CALC step: if the multiplier LSB is 1, add the multiplicand to the upper half of the 2*WIDTH+1-bit partial register; then shift the partial register right by 1.
  - At FIN:
    - r = neg ? -partial : partial, truncated to 2*WIDTH bits.
    - product <= acc_en ? (product + r) mod 2^(2*WIDTH) : r.
    - The accumulate sum wraps silently. There is no overflow flag.
- start while busy=1, including during FIN, is ignored. It is not queued.
- Operand and mode inputs are don't-care except in the cycle start is accepted.
- Iteration count always runs to WIDTH. Latency does not depend on the data; zero operands do not terminate early.

## Timing
- Reset (sys_rst=1 at an edge): state=IDLE, product=0, busy=0, done=0, iteration count and partial register = 0. Reset overrides start in the same cycle.
- Reset mid-operation aborts the multiply. The operation produces no done, and the product is cleared to 0, not retained.
- Start accepted at edge E0: busy=1 from after E0.
- CALC steps occur at edges E1..EW.
- At edge EW+1 (FIN entered after EW): product updated and done=1 for exactly one cycle.
- After edge EW+2: busy=0 and done=0.
- Latency: start edge to product valid = WIDTH+1 cycles. Issue interval = WIDTH+2 cycles minimum; start may be held high continuously.
- Outputs are registered, with no combinational path from inputs to outputs.
- busy=0 in the cycle after done falls. A start presented in that cycle is accepted.

## Test plan
- Unsigned, WIDTH=4: op_a=15, op_b=15, start pulse -> product=0xE1 (225), done high 5 cycles after the start edge, busy high for 6 cycles.
- Signed, WIDTH=4:
  - -8*-8 -> 0x40.
  - -8*7 -> 0xC8 (-56).
  - 5*-3 -> 0xF1 (-15).
  - 0*-8 -> 0x00.
- Accumulate:
  - 3*5 with acc_en=0 -> 0x0F.
  - Then 2*4 with acc_en=1 -> 0x17.
  - Then signed -1*1 with acc_en=1 -> 0x16.
  - Wrap case: 0xE1 with acc_en=1 and 15*15 -> 0xC2.
- start held high during busy with changed operands -> ignored. Exactly one done per accepted start; back-to-back result matches the operands sampled at each accepted start.
- sys_rst asserted at CALC step 2 -> no done, product=0, busy=0 next cycle; a new start then completes normally.
- WIDTH=8 and WIDTH=16 builds:
  - WIDTH=8, 255*255 unsigned -> 0xFE01; -128*-128 signed -> 0x4000; latency WIDTH+1 cycles.
  - WIDTH=16, 0xFFFF*0xFFFF unsigned -> 0xFFFE0001; latency WIDTH+1 cycles.
